// File: rtl/fir_sched.sv
// fir_sched: FIR engine scheduler. It owns ap_start/done/idle, the latched length and the tap-port arbitration,
// and it sequences the tap/data BRAMs (11-deep sample ring), the MAC strobes and the AXI-Stream handshakes.
module fir_sched #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start_pulse,
  input  logic                   status_rd,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   tlast_err,
  input  logic                   cfg_tap_req,
  output logic                   cfg_tap_gnt,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   tap_en,
  output logic [pADDR_WIDTH-1:0] tap_addr,
  output logic                   data_en,
  output logic [3:0]             data_we,
  output logic                   data_zero,
  output logic [pADDR_WIDTH-1:0] data_addr,
  output logic                   mac_clr,
  output logic                   mac_en
);

  localparam int CW = $clog2(Tape_Num);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_CALC, S_DRAIN, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic ap_start_q, ap_start_d;
  logic ap_done_q, ap_done_d;
  logic ap_idle_q, ap_idle_d;
  logic tlast_err_q, tlast_err_d;
  logic mac_en_q, mac_en_d;
  logic mac_clr_q, mac_clr_d;

  logic          cnt_last;
  logic          out_last;
  logic          start_ok;
  logic          ss_hs;
  logic          sm_hs;
  logic [CW-1:0] rd_idx;

  function automatic logic [pADDR_WIDTH-1:0] baddr(
    input logic [CW-1:0] idx
  );
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign cnt_last = (cnt_q == CW'(Tape_Num - 1));
  assign out_last = (out_cnt_q == len_q - pDATA_WIDTH'(1));
  assign start_ok = (state_q == S_IDLE) && ap_start_pulse;
  assign ss_hs    = (state_q == S_WAIT) && ss_tvalid;
  assign sm_hs    = (state_q == S_OUT) && sm_tready;

  // Newest sample sits at wr_ptr; tap j pairs with the sample j steps back.
  always_comb begin
    if (wr_ptr_q >= cnt_q) rd_idx = wr_ptr_q - cnt_q;
    else rd_idx = wr_ptr_q + CW'(Tape_Num) - cnt_q;
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      len_q       <= '0;
      out_cnt_q   <= '0;
      ap_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      ap_idle_q   <= 1'b1;
      tlast_err_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      len_q       <= len_d;
      out_cnt_q   <= out_cnt_d;
      ap_start_q  <= ap_start_d;
      ap_done_q   <= ap_done_d;
      ap_idle_q   <= ap_idle_d;
      tlast_err_q <= tlast_err_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ap_start_pulse) state_d = S_INIT;
      S_INIT: begin
        if (cnt_last) begin
          state_d = (len_q == '0) ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT:  if (ss_tvalid) state_d = S_CALC;
      S_CALC:  if (cnt_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (sm_tready) state_d = out_last ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = '0;
    wr_ptr_d    = wr_ptr_q;
    len_d       = len_q;
    out_cnt_d   = out_cnt_q;
    ap_start_d  = ap_start_q;
    ap_done_d   = ap_done_q;
    ap_idle_d   = ap_idle_q;
    tlast_err_d = tlast_err_q;
    mac_en_d    = (state_q == S_CALC);
    mac_clr_d   = (state_q == S_CALC) && (cnt_q == '0);

    if ((state_q == S_INIT || state_q == S_CALC) && !cnt_last) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (state_q == S_INIT && cnt_last) wr_ptr_d = '0;
    if (state_q == S_DRAIN) begin
      wr_ptr_d = (wr_ptr_q == CW'(Tape_Num - 1)) ? '0 : wr_ptr_q + CW'(1);
    end

    if (status_rd && ap_idle_q) ap_done_d = 1'b0;

    if (start_ok) begin
      len_d       = data_length;
      out_cnt_d   = '0;
      ap_start_d  = 1'b1;
      ap_idle_d   = 1'b0;
      ap_done_d   = 1'b0;
      tlast_err_d = 1'b0;
    end

    if (state_q == S_INIT && cnt_last && len_q == '0) begin
      ap_start_d = 1'b0;
      ap_idle_d  = 1'b1;
      ap_done_d  = 1'b1;
    end

    if (ss_hs) begin
      ap_start_d = 1'b0;
      if (ss_tlast != out_last) tlast_err_d = 1'b1;
    end

    if (sm_hs) begin
      if (out_last) begin
        out_cnt_d = '0;
        ap_idle_d = 1'b1;
        ap_done_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + pDATA_WIDTH'(1);
      end
    end
  end

  always_comb begin
    cfg_tap_gnt = 1'b0;
    ss_tready   = 1'b0;
    sm_tvalid   = 1'b0;
    sm_tlast    = 1'b0;
    tap_en      = 1'b0;
    tap_addr    = '0;
    data_en     = 1'b0;
    data_we     = 4'h0;
    data_zero   = 1'b0;
    data_addr   = '0;
    unique case (state_q)
      S_IDLE: cfg_tap_gnt = cfg_tap_req;
      S_INIT: begin
        data_en   = 1'b1;
        data_we   = 4'hF;
        data_zero = 1'b1;
        data_addr = baddr(cnt_q);
      end
      S_WAIT: begin
        ss_tready = 1'b1;
        data_addr = baddr(wr_ptr_q);
        if (ss_tvalid) begin
          data_en = 1'b1;
          data_we = 4'hF;
        end
      end
      S_CALC: begin
        tap_en    = 1'b1;
        tap_addr  = baddr(cnt_q);
        data_en   = 1'b1;
        data_addr = baddr(rd_idx);
      end
      S_DRAIN: ;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = out_last;
      end
      default: ;
    endcase
  end

  assign ap_start  = ap_start_q;
  assign ap_done   = ap_done_q;
  assign ap_idle   = ap_idle_q;
  assign tlast_err = tlast_err_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;

endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: bench for fir_sched with BRAM and MAC models around the scheduler.
// A scoreboard holds the reference FIR result and the expected tlast for every sample it accepts.
module tb_fir_sched;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start_pulse, status_rd;
  logic [DW-1:0] data_length;
  logic          ap_start, ap_done, ap_idle, tlast_err;
  logic          cfg_tap_req, cfg_tap_gnt;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic          sm_tready, sm_tvalid, sm_tlast;
  logic          tap_en, data_en, data_zero, mac_clr, mac_en;
  logic [AW-1:0] tap_addr, data_addr;
  logic [3:0]    data_we;
  logic [31:0]   ss_tdata;

  fir_sched #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .ap_start_pulse(ap_start_pulse), .status_rd(status_rd),
    .data_length(data_length),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .tlast_err(tlast_err),
    .cfg_tap_req(cfg_tap_req), .cfg_tap_gnt(cfg_tap_gnt),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast),
    .tap_en(tap_en), .tap_addr(tap_addr),
    .data_en(data_en), .data_we(data_we), .data_zero(data_zero),
    .data_addr(data_addr),
    .mac_clr(mac_clr), .mac_en(mac_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [31:0] tmem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] t_rd, d_rd, acc;
  int cyc = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tmem[i] = (i < NT) ? 32'(i + 1) : 32'h0;
      dmem[i] = 32'hDEAD_BEEF;
    end
    t_rd = '0;
    d_rd = '0;
    acc  = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_en) begin
      if (data_we != 4'h0) dmem[data_addr[AW-1:2]] <= data_zero ? 32'h0 : ss_tdata;
      d_rd <= dmem[data_addr[AW-1:2]];
    end
    if (tap_en) t_rd <= tmem[tap_addr[AW-1:2]];
    if (mac_en) acc <= mac_clr ? t_rd * d_rd : acc + t_rd * d_rd;
  end

  typedef struct {
    logic [31:0] y;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] xs [0:1023];
  int run_len = 0;
  int src_n = 0;
  int cur_n = 0;
  int cj = 0;
  int out_seen = 0;
  int flip_a = -1;
  int flip_b = -1;
  int last_take = 0;
  bit src_en = 0;
  bit spc_en = 0;

  function automatic logic [31:0] fir_ref(input int n);
    logic [31:0] s = 0;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0) s += 32'(k + 1) * xs[n - k];
    return s;
  endfunction

  initial begin
    bit took;
    exp_t e;
    ss_tvalid = 0;
    ss_tlast  = 0;
    ss_tdata  = 0;
    forever begin
      @(negedge clk);
      took = 0;
      if (sm_tvalid && sm_tready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("y", acc, e.y);
          check("sm_tlast", sm_tlast, e.last);
        end
        out_seen++;
      end
      if (tap_en) begin
        check("tap_addr", tap_addr, 64'(4 * cj));
        check("calc_addr", data_addr, 64'(4 * (((cur_n % NT) - cj + NT) % NT)));
        check("calc_we", data_we, 0);
        cj++;
      end
      if (ss_tvalid && ss_tready) begin
        took = 1;
        check("wr_addr", data_addr, 64'(4 * (src_n % NT)));
        check("wr_we", data_we, 4'hF);
        if (spc_en && src_n > 0) check("spacing", 64'(cyc - last_take), 14);
        last_take = cyc;
        xs[src_n] = ss_tdata;
        e.y = fir_ref(src_n);
        e.last = (src_n == run_len - 1);
        sb_q.push_back(e);
        cur_n = src_n;
        cj = 0;
        src_n++;
      end
      @(posedge clk);
      #1;
      ss_tvalid = src_en;
      if (took) ss_tdata = $urandom_range(0, 255);
      ss_tlast = (src_n == run_len - 1) ^ (src_n == flip_a) ^ (src_n == flip_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int len);
    int n;
    run_len = len;
    data_length = DW'(len);
    src_n = 0;
    out_seen = 0;
    sb_q.delete();
    tick();
    ap_start_pulse = 1;
    tick();
    ap_start_pulse = 0;
    n = 0;
    @(negedge clk);
    check("run_ap_start", ap_start, 1);
    check("run_ap_idle", ap_idle, 0);
    while (data_zero && n < 20) begin
      check("init_addr", data_addr, 64'(4 * n));
      check("init_we", data_we, 4'hF);
      n++;
      @(negedge clk);
    end
    check("init_cycles", n, NT);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!ap_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", ap_done, 1);
    tick();
  endtask

  task automatic wait_tap(input int limit);
    int n = 0;
    while (!tap_en && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("calc_seen", tap_en, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle"}, ap_idle, 1);
    check({tag, "_start"}, ap_start, 0);
    check({tag, "_ss_rdy"}, ss_tready, 0);
    check({tag, "_sm_vld"}, sm_tvalid, 0);
    check({tag, "_tap_en"}, tap_en, 0);
    check({tag, "_mac_en"}, mac_en, 0);
  endtask

  initial begin
    rst_n = 0;
    ap_start_pulse = 0;
    status_rd = 0;
    data_length = '0;
    cfg_tap_req = 0;
    sm_tready = 0;
    repeat (3) tick();
    rst_n = 1;
    @(negedge clk);
    check_idle("rst");
    check("rst_done", ap_done, 0);
    check("rst_terr", tlast_err, 0);
    check("gnt_lo", cfg_tap_gnt, 0);
    tick();
    cfg_tap_req = 1;
    @(negedge clk);
    check("gnt_hi", cfg_tap_gnt, 1);
    tick();
    cfg_tap_req = 0;

    // long run with continuous handshakes
    sm_tready = 1;
    src_en = 1;
    spc_en = 1;
    do_start(600);
    wait_tap(100);
    wait_tap(100);
    tick();
    cfg_tap_req = 1;
    ap_start_pulse = 1;
    @(negedge clk);
    check("gnt_calc", cfg_tap_gnt, 0);
    check("start_clr", ap_start, 0);
    tick();
    ap_start_pulse = 0;
    cfg_tap_req = 0;
    wait_done(12000);
    check("r1_outs", out_seen, 600);
    check("r1_sb", sb_q.size(), 0);
    check("r1_idle", ap_idle, 1);
    check("r1_done", ap_done, 1);
    check("r1_terr", tlast_err, 0);
    spc_en = 0;

    // output backpressure
    sm_tready = 0;
    do_start(4);
    for (int i = 0; i < 100 && !sm_tvalid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", sm_tvalid, 1);
      check("bp_ss_rdy", ss_tready, 0);
      check("bp_mac", mac_en, 0);
      @(negedge clk);
    end
    tick();
    sm_tready = 1;
    wait_done(200);
    check("bp_outs", out_seen, 4);

    // mismatched tlast on samples 1 and 2
    flip_a = 1;
    flip_b = 2;
    do_start(3);
    wait_done(200);
    check("tl_outs", out_seen, 3);
    check("tl_err", tlast_err, 1);
    check("tl_done", ap_done, 1);
    status_rd = 1;
    tick();
    status_rd = 0;
    @(negedge clk);
    check("rd_done", ap_done, 0);
    check("rd_idle", ap_idle, 1);
    check("rd_terr", tlast_err, 1);
    flip_a = -1;
    flip_b = -1;

    // zero length
    src_en = 0;
    do_start(0);
    check("z_done", ap_done, 1);
    check_idle("z");
    check("z_terr", tlast_err, 0);

    // reset in the middle of CALC
    src_en = 1;
    do_start(50);
    wait_tap(100);
    #1;
    rst_n = 0;
    src_en = 0;
    @(negedge clk);
    check_idle("mr");
    check("mr_done", ap_done, 0);
    check("mr_data_en", data_en, 0);
    check("mr_clr", mac_clr, 0);
    tick();
    rst_n = 1;
    src_en = 1;
    do_start(2);
    wait_done(200);
    check("mr_outs", out_seen, 2);
    check("mr_sb", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
